// File: rtl/ipv4_vlg_pkg.sv
// Shared IPv4 header types and ones-complement helpers for the TX framer and
// the RX checker.
package ipv4_vlg_pkg;

    localparam int IPV4_HDR_LEN   = 20;
    localparam int IPV4_HDR_WORDS = 10;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] len;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] cks;
        logic [31:0] src;
        logic [31:0] dst;
    } ipv4_hdr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_FOLD,
        S_HDR,
        S_PLD,
        S_ABORT
    } ipv4_tx_state_t;

    // Two folds: the first can itself carry out of bit 15.
    function automatic logic [15:0] ipv4_cks_fold(input logic [19:0] acc);
        logic [16:0] s;
        s = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
        s = {1'b0, s[15:0]} + {16'b0, s[16]};
        return s[15:0];
    endfunction

endpackage

// File: rtl/ipv4_vlg_cks.sv
// Word-serial ones-complement accumulator: clr, add one 16-bit word per
// cycle, then fold to the inverted header checksum.
module ipv4_vlg_cks
    import ipv4_vlg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [15:0] i_word,
    input  logic        i_fold,
    output logic [15:0] o_cks
);

    logic [19:0] r_acc;
    logic [15:0] r_cks;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_cks <= '0;
        end else begin
            if (i_clr)
                r_acc <= '0;
            else if (i_add)
                r_acc <= r_acc + {4'b0, i_word};
            if (i_fold)
                r_cks <= ~ipv4_cks_fold(r_acc);
        end
    end

    assign o_cks = r_cks;

endmodule

// File: rtl/ipv4_vlg_hdr_tx.sv
// IPv4 TX framer: 20-byte header with computed checksum, then payload
// pass-through. Optional payload-underrun abort under IPV4_TX_UNDERRUN_EN.
module ipv4_vlg_hdr_tx
    import ipv4_vlg_pkg::*;
#(
    parameter logic [7:0] TTL            = 8'd64,
    parameter logic       DF             = 1'b1,
    parameter int         UNDERRUN_TICKS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_strt,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [7:0]  i_proto,
    input  logic [15:0] i_len,
    input  logic [15:0] i_id,
    output logic        o_busy,
    input  logic [7:0]  i_pld_dat,
    input  logic        i_pld_val,
    output logic        o_pld_rdy,
    output logic [7:0]  o_out_dat,
    output logic        o_out_val,
    output logic        o_out_sof,
    output logic        o_out_eof,
    input  logic        i_out_rdy,
    output logic        o_err
);

    localparam int IW = $clog2(UNDERRUN_TICKS + 1);
    localparam logic [IW-1:0] UR_MAX = IW'(UNDERRUN_TICKS);
`ifdef IPV4_TX_UNDERRUN_EN
    localparam logic [IW-1:0] UR_LAST = IW'(UNDERRUN_TICKS - 1);
`endif

    ipv4_tx_state_t  r_state;
    ipv4_hdr_t       r_hdr;
    logic [4:0]      r_cnt;
    logic [15:0]     r_rem;
    logic [IW-1:0]   r_idle;

    logic [15:0]     w_len;
    logic [15:0]     w_cks;
    ipv4_hdr_t       w_hdr_out;
    logic [9:0][15:0] w_words;
    logic [19:0][7:0] w_bytes;
    logic [3:0]      w_widx;
    logic [4:0]      w_bidx;

    assign w_len = (i_len < 16'(IPV4_HDR_LEN)) ? 16'(IPV4_HDR_LEN) : i_len;

    // r_hdr holds cks=0, so the summed words see a zero checksum field.
    assign w_words = r_hdr;
    assign w_widx  = 4'd9 - r_cnt[3:0];
    assign w_bidx  = 5'd19 - r_cnt;

    always_comb begin
        w_hdr_out     = r_hdr;
        w_hdr_out.cks = w_cks;
    end
    assign w_bytes = w_hdr_out;

    ipv4_vlg_cks u_cks (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (r_state == S_IDLE && i_strt),
        .i_add  (r_state == S_SUM),
        .i_word (w_words[w_widx]),
        .i_fold (r_state == S_FOLD),
        .o_cks  (w_cks)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_hdr   <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_idle  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_idle <= '0;
                    if (i_strt) begin
                        r_hdr <= '{version: 4'd4, ihl: 4'd5, tos: 8'd0,
                                   len: w_len, id: i_id,
                                   flags: {1'b0, DF, 1'b0}, frag: 13'd0,
                                   ttl: TTL, proto: i_proto, cks: 16'd0,
                                   src: i_src_ip, dst: i_dst_ip};
                        r_rem   <= w_len - 16'(IPV4_HDR_LEN);
                        r_state <= S_SUM;
                    end
                end
                S_SUM: begin
                    if (r_cnt == 5'(IPV4_HDR_WORDS - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FOLD;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FOLD: r_state <= S_HDR;
                S_HDR: begin
                    if (i_out_rdy) begin
                        if (r_cnt == 5'(IPV4_HDR_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= (r_rem == 16'd0) ? S_IDLE : S_PLD;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_PLD: begin
                    if (i_pld_val && i_out_rdy) begin
                        r_rem  <= r_rem - 16'd1;
                        r_idle <= '0;
                        if (r_rem == 16'd1)
                            r_state <= S_IDLE;
                    end else if (!i_pld_val) begin
`ifdef IPV4_TX_UNDERRUN_EN
                        if (r_idle == UR_LAST)
                            r_state <= S_ABORT;
`endif
                        if (r_idle != UR_MAX)
                            r_idle <= r_idle + IW'(1);
                    end
                end
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Header bytes come from registered state; payload is a zero-latency bypass.
    always_comb begin
        o_out_val = 1'b0;
        o_out_dat = 8'd0;
        o_out_sof = 1'b0;
        o_out_eof = 1'b0;
        o_pld_rdy = 1'b0;
        case (r_state)
            S_HDR: begin
                o_out_val = 1'b1;
                o_out_dat = w_bytes[w_bidx];
                o_out_sof = (r_cnt == 5'd0);
                o_out_eof = (r_cnt == 5'(IPV4_HDR_LEN - 1)) && (r_rem == 16'd0);
            end
            S_PLD: begin
                o_pld_rdy = i_out_rdy;
                o_out_val = i_pld_val;
                o_out_dat = i_pld_dat;
                o_out_eof = i_pld_val && (r_rem == 16'd1);
            end
            S_ABORT: begin
                o_out_val = 1'b1;
                o_out_eof = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef IPV4_TX_UNDERRUN_EN
    assign o_err = (r_state == S_ABORT);
`else
    assign o_err = 1'b0;
`endif

    assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_ipv4_vlg_hdr_tx.sv
// Directed bench for ipv4_vlg_hdr_tx with a byte scoreboard; the underrun
// case is built only when IPV4_TX_UNDERRUN_EN is defined.
module tb_ipv4_vlg_hdr_tx;

    logic        clk = 1'b0;
    logic        rst, strt, pld_val, out_rdy;
    logic [31:0] src, dst;
    logic [7:0]  proto, pld_dat;
    logic [15:0] len, id;
    logic        busy, pld_rdy, out_val, out_sof, out_eof, err;
    logic [7:0]  out_dat;

    int ncmp = 0;
    int nmis = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ipv4_vlg_hdr_tx dut (
        .i_clk(clk), .i_rst(rst), .i_strt(strt),
        .i_src_ip(src), .i_dst_ip(dst), .i_proto(proto),
        .i_len(len), .i_id(id), .o_busy(busy),
        .i_pld_dat(pld_dat), .i_pld_val(pld_val), .o_pld_rdy(pld_rdy),
        .o_out_dat(out_dat), .o_out_val(out_val), .o_out_sof(out_sof),
        .o_out_eof(out_eof), .i_out_rdy(out_rdy), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference header: explicit word list, 32-bit sum folded until no carry.
    task automatic push_hdr(input logic [15:0] l, input logic [15:0] i,
                            input logic [31:0] s, input logic [31:0] d,
                            input logic [7:0] p);
        logic [15:0] w[10];
        logic [31:0] sum;
        w = '{16'h4500, l, i, 16'h4000, {8'd64, p}, 16'h0000,
              s[31:16], s[15:0], d[31:16], d[15:0]};
        sum = 0;
        for (int k = 0; k < 10; k++) sum += {16'h0, w[k]};
        while (sum[31:16] != 0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        w[5] = ~sum[15:0];
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(w[k][15:8]);
            exp_q.push_back(w[k][7:0]);
        end
    endtask

    task automatic run(input string nm, input logic [15:0] t_len, input logic [15:0] t_id,
                       input logic [31:0] t_src, input logic [31:0] t_dst,
                       input logic [7:0] t_proto, input logic [7:0] pbase,
                       input bit rnd, input int ign_at, input int rst_at, input int stall_at);
        logic [7:0] pay[$];
        int npay, nbytes, pi, cyc, first, nout, last_x;
        bit done, saw_rdy, rst_pend;
        npay = int'(t_len) - 20;
        push_hdr(t_len, t_id, t_src, t_dst, t_proto);
        for (int k = 0; k < npay; k++) begin
            pay.push_back(pbase + 8'(k));
            exp_q.push_back(pbase + 8'(k));
        end
        nbytes = exp_q.size();
        @(negedge clk);
        strt = 1'b1; len = t_len; id = t_id; src = t_src; dst = t_dst; proto = t_proto;
        pld_val = 1'b0; out_rdy = 1'b1; pld_dat = 8'hEE;
        #1 chk({nm, "_busy_pre"}, busy, 0);
        cyc = 0; first = -1; pi = 0; nout = 0; last_x = 0;
        done = 0; saw_rdy = 0; rst_pend = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (rst_pend) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk({nm, "_rst_val"}, out_val, 0);
                chk({nm, "_rst_busy"}, busy, 0);
                chk({nm, "_rst_rdy"}, pld_rdy, 0);
                chk({nm, "_rst_eof"}, {out_sof, out_eof, err}, 0);
                exp_q.delete();
                return;
            end
            strt = (cyc == ign_at);
            if (strt) begin
                id = ~t_id; src = 32'h0A0B0C0D; len = 16'd40;
            end
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pld_val = (pi < npay) && !(stall_at >= 0 && pi >= stall_at);
            pld_dat = (pi < npay) ? pay[pi] : 8'hEE;
            #1;
            if (pld_rdy) saw_rdy = 1;
            if (out_val && first < 0) first = cyc;
            if (err) begin
                chk({nm, "_abort_val"}, out_val, 1);
                chk({nm, "_abort_eof"}, out_eof, 1);
                chk({nm, "_abort_dat"}, out_dat, 0);
                chk({nm, "_abort_lat"}, cyc - last_x, 17);
                @(negedge clk);
                #1;
                chk({nm, "_abort_busy"}, busy, 0);
                chk({nm, "_abort_err1"}, err, 0);
                exp_q.delete();
                return;
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk({nm, "_extra_byte"}, nout, nbytes);
                end else begin
                    chk({nm, "_dat"}, out_dat, exp_q.pop_front());
                    chk({nm, "_sof"}, out_sof, nout == 0);
                    chk({nm, "_eof"}, out_eof, exp_q.size() == 0);
                end
                nout++;
                if (out_eof) done = 1;
            end
            if (pld_val && pld_rdy) begin
                pi++;
                last_x = cyc;
                if (rst_at >= 0 && pi == rst_at) rst_pend = 1;
            end
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_latency"}, first, 12);
        chk({nm, "_nbytes"}, nout, nbytes);
        chk({nm, "_pld_rdy_seen"}, saw_rdy, npay > 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; strt = 0; pld_val = 0; out_rdy = 1; pld_dat = 0;
        src = 0; dst = 0; proto = 0; len = 0; id = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_val", out_val, 0);
        chk("rst_pld_rdy", pld_rdy, 0);
        chk("rst_flags", {out_sof, out_eof, err}, 0);
        chk("rst_dat", out_dat, 0);
        @(negedge clk);
        rst = 1'b0;

        run("udp115", 16'h0073, 16'h0000, 32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 0, -1, -1, -1);
        run("hdr_only", 16'd20, 16'h1234, 32'h0A000001, 32'h0A000002, 8'h06, 8'h00, 0, -1, -1, -1);
        run("ramp_rdy1", 16'd64, 16'hBEEF, 32'hAC100001, 32'hAC1000FE, 8'h01, 8'h00, 0, -1, -1, -1);
        run("ramp_rnd", 16'd64, 16'hBEEF, 32'hAC100001, 32'hAC1000FE, 8'h01, 8'h00, 1, -1, -1, -1);
        run("ign_strt", 16'd30, 16'h0042, 32'h01020304, 32'h05060708, 8'h11, 8'h80, 0, 20, -1, -1);
        run("b2b", 16'd25, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'h10, 1, -1, -1, -1);
        run("rst_mid", 16'd40, 16'h0007, 32'hC0A80001, 32'hC0A80002, 8'h11, 8'h00, 0, -1, 5, -1);
        run("post_rst", 16'd26, 16'h0008, 32'hC0A80003, 32'hC0A80004, 8'h11, 8'h30, 0, -1, -1, -1);
`ifdef IPV4_TX_UNDERRUN_EN
        run("underrun", 16'd40, 16'h0009, 32'hC0A80005, 32'hC0A80006, 8'h11, 8'h00, 0, -1, -1, 3);
        run("post_abort", 16'd22, 16'h000A, 32'hC0A80007, 32'hC0A80008, 8'h11, 8'h50, 0, -1, -1, -1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule

// File: doc/ipv4_vlg_hdr_tx.md
Name: ipv4_vlg_hdr_tx

Overview:
Transmit-side IPv4 framer. Latches header fields on a start strobe and computes the header checksum. Emits a byte stream of a 20-byte IPv4 header (no options) followed by the caller's payload bytes, with backpressure from the MAC-side consumer. Sits between the transport-layer TX muxes (TCP/UDP/ICMP) and the MAC TX path, and is the counterpart to the IPv4 RX header parser.

Parameters:
TTL, 8'd64, Time To Live written into every header.
DF, 1'b1, value of the Don't-Fragment flag; MF and fragment offset are always 0.
UNDERRUN_TICKS, 16, idle cycles tolerated on payload input before abort (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
strt  in  1  start strobe; sampled only when busy=0
src_ip  in  32  source IPv4 address
dst_ip  in  32  destination IPv4 address
proto  in  8  protocol field
len  in  16  total length, header included; legal range 20..65535
id  in  16  identification
busy  out  1  high from accepted strt until the last byte is accepted
pld_dat  in  8  payload byte
pld_val  in  1  payload byte valid
pld_rdy  out  1  payload byte accepted this cycle when pld_val&pld_rdy
out_dat  out  8  output byte
out_val  out  1  output byte valid
out_sof  out  1  first header byte
out_eof  out  1  last byte of the datagram
out_rdy  in  1  downstream accepts the byte when out_val&out_rdy
err  out  1  one-cycle pulse on an aborted datagram

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and accumulator 0. A reset mid-datagram drops the datagram immediately with no eof.
- FSM: IDLE -> SUM -> FOLD -> HDR -> PLD -> IDLE.
- IDLE: strt=1 latches all fields and enters SUM; busy=1 from the next cycle. strt while busy is ignored.
- len<20: treated as 20 (header only, no PLD state).
- SUM: 10 cycles; adds one 16-bit header word per cycle into a 20-bit accumulator. The checksum word is taken as 0. Word order: 0x45_00, len, id, {DF,14'b0} placed in bits 14/13 as {1'b0,DF,1'b0,13'b0}, {TTL,proto}, src hi, src lo, dst hi, dst lo.
- FOLD: 1 cycle; sum = acc[15:0]+acc[19:16], folded once more for end-around carry; checksum = ~sum.
- strt to first out_val latency: 12 cycles.
- HDR: bytes are emitted MSB first in the word order above, with the checksum in bytes 10-11.
  - The byte counter advances only on out_val&out_rdy; out_val stays high and out_dat is held while out_rdy=0.
  - out_sof accompanies byte 0.
  - If len==20, out_eof accompanies byte 19 and the FSM returns to IDLE.
- PLD: pld_rdy = out_rdy; out_val = pld_val; out_dat = pld_dat (combinational pass-through, zero latency).
  - 16-bit remaining counter = len-20, decremented per transfer.
  - out_eof goes high on the transfer where remaining==1; the FSM then goes to IDLE, pld_rdy=0, and busy=0 on the next cycle.
- Back-to-back: strt in the first IDLE cycle after eof is accepted.
- Payload bytes beyond the counted length are never consumed (pld_rdy=0 outside PLD).

Optional Feature:
IPV4_TX_UNDERRUN_EN:
- Defined: in PLD, a counter resets on every transfer and counts cycles with pld_val=0. Reaching UNDERRUN_TICKS forces one output cycle with out_val=1, out_eof=1, out_dat=0, and err=1, then IDLE. out_rdy is not required for the abort.
- Undefined: PLD waits on pld_val indefinitely and err is tied 0.

Decomposition:
- ipv4_vlg_pkg receives: IPV4_HDR_LEN=20, ipv4_hdr_t packed struct (version/ihl/tos/len/id/flags/frag/ttl/proto/cks/src/dst), function ipv4_cks_fold(logic [19:0]) returning logic [15:0].
- One sub-module: ipv4_vlg_cks, a word-serial ones-complement accumulator with clr/add/fold. It is reused by the future RX check.

Test Plan:
- src=192.168.0.1, dst=192.168.0.199, proto=0x11, len=0x0073, id=0, TTL=64, DF=1 -> header bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, followed by 95 payload bytes; eof on byte 115; first out_val 12 cycles after strt.
- len=20 -> exactly 20 bytes, sof on byte 0, eof on byte 19, pld_rdy never asserted.
- Random out_rdy (50% duty) over len=64 with a 0..43 payload ramp -> output identical to the out_rdy=1 case; no byte dropped or duplicated.
- strt pulsed during busy -> ignored; the second strt immediately after eof -> second datagram correct.
- rst asserted on payload byte 5 -> all outputs 0 next cycle; a new strt yields a correct full datagram.
- With IPV4_TX_UNDERRUN_EN, UNDERRUN_TICKS=16, pld_val held low after 3 payload bytes -> err and out_eof on the abort byte 16 cycles later; busy=0 the following cycle.
